lcd_bus_sequencer: RTL
======================

Name: lcd_bus_sequencer

Overview:
- Downstream consumer of the LSU's LCD control register.
- Converts each store to the LCD address window into a correctly timed HD44780-style parallel write: RS/data setup, EN pulse, hold, then command execution wait.
- Buffers one pending transfer so software stores are never stretched.
- Exposes a status word that the core can mux back onto the load path.

Parameters:
- T_AS, 4, cycles RS/data stable before EN rises (min 1)
- T_PW, 25, cycles EN held high (min 1)
- T_H, 2, cycles RS/data held after EN falls (min 1)
- T_EXEC, 2500, cycles wait after a normal command/data byte (50 us at 50 MHz)
- T_EXEC_LONG, 82000, cycles wait after clear (0x01) or home (0x02/0x03) commands
- T_PWRUP, 750000, cycles power-up wait before init sequence (used only with the optional feature)
- CNT_W, 20, width of the shared down-counter; must hold the largest T_* minus 1

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_lcd_wr  in  1  one-cycle strobe: store hit the LCD register (lcd_enable & wren)
- i_lcd_word  in  32  stored word: [31]=on, [10]=clear overflow, [9]=send, [8]=RS, [7:0]=data
- o_lcd_on  out  1  panel power/backlight enable
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write; tied 0 (write-only block)
- o_lcd_en  out  1  enable strobe
- o_lcd_data  out  8  data bus
- o_busy  out  1  FSM not IDLE, or pending slot full
- o_status  out  32  {29'b0, overflow, pending_valid, busy}

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-high. While it is asserted, every output is 0, the FSM is IDLE, the pending slot is empty, overflow is 0 and the counter is 0. This holds even mid-transfer: EN drops immediately.
- On-bit: o_lcd_on takes i_lcd_word[31] on the cycle after every i_lcd_wr, regardless of busy or the send bit.
- Overflow clear: i_lcd_word[10]=1 with i_lcd_wr clears overflow. If an overflow event occurs in the same cycle, set wins.
- Send=0 writes update on/clear only. No transfer is queued.
- Send=1 acceptance, one of three outcomes:
  - FSM IDLE and pending empty: {RS, data} load into the active register; next cycle the FSM is in SETUP.
  - Otherwise, pending empty: {RS, data} go to the pending slot.
  - Otherwise (pending full): the write is dropped, overflow sets (sticky), active and pending are unchanged.
- FSM states and outputs:
  - IDLE: EN=0.
  - SETUP: T_AS cycles, EN=0, RS/data driven from the active register.
  - EN_HIGH: T_PW cycles, EN=1.
  - HOLD: T_H cycles, EN=0, RS/data unchanged.
  - EXEC: EN=0; lasts T_EXEC_LONG cycles if RS=0 and data is 0x01, 0x02 or 0x03, else T_EXEC cycles.
- Transitions: each state loads the counter with T_x−1 on entry and exits when the counter is 0.
  - EXEC exit with pending valid: pending moves to active, the FSM enters SETUP directly (no IDLE cycle), pending empties.
  - EXEC exit with pending empty: go to IDLE.
- Simultaneous events:
  - A send=1 write in the same cycle pending drains at EXEC exit refills pending; no overflow.
  - A write in the IDLE cycle itself is accepted directly.
- Bus behaviour: o_lcd_rs/o_lcd_data hold the last transferred values while IDLE. o_lcd_rw is constantly 0.
- Latency: a write from IDLE gives EN rising T_AS+1 cycles after the strobe. Total occupancy is T_AS+T_PW+T_H+T_EXEC(_LONG) cycles.
- Arithmetic and timing: the counter is unsigned and never wraps, because reload always occurs on state entry.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- With the macro: after reset release the FSM enters PWRUP for T_PWRUP cycles, then an internal ROM issues RS=0 bytes 0x38, 0x0C, 0x06, 0x01 through the normal SETUP→EXEC path.
  - o_busy=1 throughout.
  - User send=1 writes during init go to the pending slot, or set overflow, under the normal rules. Pending is serviced after the last init byte.
- Without the macro: there is no PWRUP state and no ROM, and the FSM is IDLE one cycle after reset release.

Test Plan:
All scenarios run with T_AS=2, T_PW=3, T_H=1, T_EXEC=5, T_EXEC_LONG=9, macro off unless stated.
1. Reset behaviour: reset asserted mid-EN_HIGH -> EN=0, busy=0, status=0 in the same cycle; after release IDLE.
2. Single data write: i_lcd_wr with word 0x0000_0341 -> RS=1, data=0x41, EN high for exactly 3 cycles starting 3 cycles after the strobe, busy for 11 cycles.
3. Clear command: word 0x0000_0201 -> EXEC lasts 9 cycles; total busy 15 cycles.
4. Back-to-back writes: three send writes at cycles 0, 1, 2 -> bytes 1 and 2 transferred with no IDLE gap between them; byte 3 dropped; status=0x5 until the write 0x0000_0400, then status reflects busy only.
5. On-only and drain/refill: word 0x8000_0000 -> o_lcd_on=1 next cycle, no EN pulse. A send write exactly at the EXEC exit cycle while pending is full -> accepted into pending, overflow stays 0.
6. With LCD_INIT_SEQ_EN and T_PWRUP=10: after reset -> 10 cycles idle bus, then EN pulses carrying 0x38, 0x0C, 0x06, 0x01 in order with RS=0; the last uses long EXEC; busy deasserts only after the last EXEC.

Source files
------------

// File: rtl/lcd_bus_sequencer_if.sv
// LCD sequencer bus: store strobe/word from the LSU side, HD44780 pins and
// status back out. The sequencer sits on the slave modport; the core or a
// bench drives through the master modport.
interface lcd_bus_sequencer_if;
  logic        i_lcd_wr;
  logic [31:0] i_lcd_word;
  logic        o_lcd_on;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic [7:0]  o_lcd_data;
  logic        o_busy;
  logic [31:0] o_status;

  modport slave (
    input  i_lcd_wr, i_lcd_word,
    output o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data, o_busy, o_status
  );

  modport master (
    output i_lcd_wr, i_lcd_word,
    input  o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data, o_busy, o_status
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: turns stores to the LCD register into timed HD44780
// writes (setup, EN pulse, hold, execution wait) with a one-deep pending slot
// and a sticky overflow flag. Optional macro LCD_INIT_SEQ_EN adds a power-up
// wait followed by the panel init bytes 0x38, 0x0C, 0x06, 0x01.
module lcd_bus_sequencer #(
  parameter int unsigned T_AS        = 4,
  parameter int unsigned T_PW        = 25,
  parameter int unsigned T_H         = 2,
  parameter int unsigned T_EXEC      = 2500,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned T_PWRUP     = 750000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  lcd_bus_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EN_HIGH, S_HOLD, S_EXEC, S_PWRUP
  } state_t;

  // Counter reload values: each state lasts exactly T_x cycles.
  localparam logic [CNT_W-1:0] LD_AS    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_H     = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] LD_EX    = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_EXL   = CNT_W'(T_EXEC_LONG - 1);
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             en_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             pend_v_q;
  logic             pend_rs_q;
  logic [7:0]       pend_data_q;
  logic             on_q;
  logic             ovf_q;

  logic wr_send, cnt_zero, exec_done, exec_long, init_done;
  logic accept_direct, drain, pend_free, to_pend, ovf_set, busy;
  logic unused_ok;

`ifdef LCD_INIT_SEQ_EN
  // Index of the next init byte; reaching 4 means the ROM has been issued.
  logic [2:0] rom_idx_q;
  assign init_done = (rom_idx_q == 3'd4);

  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_byte = 8'h38;
      3'd1:    rom_byte = 8'h0C;
      3'd2:    rom_byte = 8'h06;
      default: rom_byte = 8'h01;
    endcase
  endfunction
`else
  assign init_done = 1'b1;
`endif

  assign wr_send   = bus.i_lcd_wr & bus.i_lcd_word[9];
  assign cnt_zero  = (cnt_q == '0);
  assign exec_done = (state_q == S_EXEC) && cnt_zero;
  // Clear and return-home need the long execution wait.
  assign exec_long = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  // The pending slot empties this cycle when the FSM consumes it; a write in
  // the same cycle may refill it without counting as overflow.
  assign drain         = pend_v_q && init_done && (exec_done || state_q == S_IDLE);
  assign accept_direct = wr_send && (state_q == S_IDLE) && !pend_v_q && init_done;
  assign pend_free     = !pend_v_q || drain;
  assign to_pend       = wr_send && !accept_direct && pend_free;
  assign ovf_set       = wr_send && !accept_direct && !pend_free;

`ifdef LCD_INIT_SEQ_EN
  // Busy covers the whole init sequence, including the IDLE cycle after reset.
  assign busy = (state_q != S_IDLE) || pend_v_q || (!init_done && !i_reset);
`else
  assign busy = (state_q != S_IDLE) || pend_v_q;
`endif

  assign bus.o_lcd_on   = on_q;
  assign bus.o_lcd_rs   = rs_q;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_en   = en_q;
  assign bus.o_lcd_data = data_q;
  assign bus.o_busy     = busy;
  assign bus.o_status   = {29'b0, ovf_q, pend_v_q, busy};

  assign unused_ok = ^{bus.i_lcd_word[30:11], LD_PWRUP};

  // Transfer FSM: pending slot, active byte, shared down-counter and EN pin.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= '0;
`ifdef LCD_INIT_SEQ_EN
      rom_idx_q   <= '0;
`endif
    end else begin
      if (to_pend) begin
        pend_v_q    <= 1'b1;
        pend_rs_q   <= bus.i_lcd_word[8];
        pend_data_q <= bus.i_lcd_word[7:0];
      end else if (drain) begin
        pend_v_q    <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept_direct) begin
            rs_q    <= bus.i_lcd_word[8];
            data_q  <= bus.i_lcd_word[7:0];
            state_q <= S_SETUP;
            cnt_q   <= LD_AS;
          end else if (drain) begin
            rs_q    <= pend_rs_q;
            data_q  <= pend_data_q;
            state_q <= S_SETUP;
            cnt_q   <= LD_AS;
          end
`ifdef LCD_INIT_SEQ_EN
          else if (!init_done) begin
            state_q <= S_PWRUP;
            cnt_q   <= LD_PWRUP;
          end
`endif
        end
        S_SETUP: begin
          if (cnt_zero) begin
            state_q <= S_EN_HIGH;
            cnt_q   <= LD_PW;
            en_q    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        S_EN_HIGH: begin
          if (cnt_zero) begin
            state_q <= S_HOLD;
            cnt_q   <= LD_H;
            en_q    <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state_q <= S_EXEC;
            cnt_q   <= exec_long ? LD_EXL : LD_EX;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (cnt_zero) begin
`ifdef LCD_INIT_SEQ_EN
            if (!init_done) begin
              rs_q      <= 1'b0;
              data_q    <= rom_byte(rom_idx_q);
              rom_idx_q <= rom_idx_q + 3'd1;
              state_q   <= S_SETUP;
              cnt_q     <= LD_AS;
            end else
`endif
            if (pend_v_q) begin
              rs_q    <= pend_rs_q;
              data_q  <= pend_data_q;
              state_q <= S_SETUP;
              cnt_q   <= LD_AS;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef LCD_INIT_SEQ_EN
        S_PWRUP: begin
          if (cnt_zero) begin
            rs_q      <= 1'b0;
            data_q    <= rom_byte(3'd0);
            rom_idx_q <= 3'd1;
            state_q   <= S_SETUP;
            cnt_q     <= LD_AS;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Panel-on bit follows every store; overflow is sticky, set beats clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      on_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.i_lcd_wr) on_q <= bus.i_lcd_word[31];
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (bus.i_lcd_wr && bus.i_lcd_word[10])
        ovf_q <= 1'b0;
    end
  end

endmodule
